// File: rtl/dhs_soc_ctrl_rst_seq.sv
// Per-domain clock/reset sequencer: waits for a filtered PLL lock, runs the clock with reset held, then releases reset.
// Define DHS_RST_SEQ_LOCK_MON_EN to compile in PLL lock-loss monitoring and the sticky lock_lost_o flag.
module dhs_soc_ctrl_rst_seq #(
  parameter int LOCK_FILT = 4,
  parameter int RST_DLY   = 8,
  parameter int DRAIN_DLY = 2,
  parameter int CNT_W     = 8
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       rst_req_ni,
  input  logic       clk_en_req_i,
  input  logic       pll_locked_i,
  input  logic       lock_lost_clr_i,
  output logic       clk_en_o,
  output logic       rst_n_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_CLK_ON    = 3'd2,
    ST_RUN       = 3'd3,
    ST_DRAIN     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_DLY - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_DLY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             rst_n_q, rst_n_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic             req_ok;
  logic             lock_drop;
  logic             lock_set;

  assign req_ok = rst_req_ni & clk_en_req_i;

`ifdef DHS_RST_SEQ_LOCK_MON_EN
  assign lock_drop = ~pll_locked_i;
`else
  assign lock_drop = 1'b0;
  logic unused_lock_lost_clr;
  assign unused_lock_lost_clr = lock_lost_clr_i;
`endif

  // State register; every output is a flop updated on the same edge as the state.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      clk_en_q    <= 1'b0;
      rst_n_q     <= 1'b0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_en_q    <= clk_en_d;
      rst_n_q     <= rst_n_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Next-state and shared delay counter; lock loss outranks a request drop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    lock_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_ok) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (!req_ok)                                state_d = ST_IDLE;
        else if (pll_locked_i && cnt_q == LOCK_LAST) state_d = ST_CLK_ON;
        else if (!pll_locked_i)                     cnt_d   = '0;
      end
      ST_CLK_ON: begin
        if (lock_drop) begin
          state_d  = ST_WAIT_LOCK;
          lock_set = 1'b1;
        end else if (!req_ok)          state_d = ST_DRAIN;
        else if (cnt_q == RST_LAST)    state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = '0;
        if (lock_drop) begin
          state_d  = ST_WAIT_LOCK;
          lock_set = 1'b1;
        end else if (!req_ok) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (lock_drop) begin
          state_d  = ST_IDLE;
          lock_set = 1'b1;
        end else if (cnt_q == DRAIN_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Output decode from the next state so outputs land with the state change.
  always_comb begin
    clk_en_d = 1'b0;
    rst_n_d  = 1'b0;
    ready_d  = 1'b0;
    case (state_d)
      ST_CLK_ON, ST_DRAIN: clk_en_d = 1'b1;
      ST_RUN: begin
        clk_en_d = 1'b1;
        rst_n_d  = 1'b1;
        ready_d  = 1'b1;
      end
      default: ;
    endcase
`ifdef DHS_RST_SEQ_LOCK_MON_EN
    lock_lost_d = lock_set | (lock_lost_q & ~lock_lost_clr_i);
`else
    lock_lost_d = lock_set;
`endif
  end

  assign clk_en_o    = clk_en_q;
  assign rst_n_o     = rst_n_q;
  assign ready_o     = ready_q;
  assign lock_lost_o = lock_lost_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_dhs_soc_ctrl_rst_seq.sv
// Bench for dhs_soc_ctrl_rst_seq: directed scenarios plus randomized traffic against a phase/duration reference model.
module tb_dhs_soc_ctrl_rst_seq;

  localparam int LOCK_FILT = 4;
  localparam int RST_DLY   = 8;
  localparam int DRAIN_DLY = 2;
  localparam int CNT_W     = 8;

  localparam int P_IDLE = 0, P_WAIT = 1, P_CLK_ON = 2, P_RUN = 3, P_DRAIN = 4;

  // Clock / reset
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       arst_ni, rst_req_ni, clk_en_req_i, pll_locked_i, lock_lost_clr_i;
  logic       clk_en_o, rst_n_o, ready_o, lock_lost_o;
  logic [2:0] state_o;

  dhs_soc_ctrl_rst_seq #(
    .LOCK_FILT(LOCK_FILT), .RST_DLY(RST_DLY), .DRAIN_DLY(DRAIN_DLY), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .rst_req_ni(rst_req_ni), .clk_en_req_i(clk_en_req_i),
    .pll_locked_i(pll_locked_i), .lock_lost_clr_i(lock_lost_clr_i),
    .clk_en_o(clk_en_o), .rst_n_o(rst_n_o), .ready_o(ready_o),
    .lock_lost_o(lock_lost_o), .state_o(state_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: current phase, cycles spent in it, consecutive locked cycles, sticky flag
  int m_phase    = P_IDLE;
  int m_elapsed  = 0;
  int m_lock_run = 0;
  bit m_lost     = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_edge();
    bit req  = rst_req_ni && clk_en_req_i;
    bit loss = 1'b0;
    bit set  = 1'b0;
    int nxt  = m_phase;
    if (!arst_ni) begin
      m_phase = P_IDLE; m_elapsed = 0; m_lock_run = 0; m_lost = 1'b0;
      return;
    end
`ifdef DHS_RST_SEQ_LOCK_MON_EN
    loss = !pll_locked_i;
`endif
    case (m_phase)
      P_IDLE: if (req) nxt = P_WAIT;
      P_WAIT: begin
        if (!req) nxt = P_IDLE;
        else if (pll_locked_i) begin
          m_lock_run++;
          if (m_lock_run == LOCK_FILT) nxt = P_CLK_ON;
        end else m_lock_run = 0;
      end
      P_CLK_ON: begin
        m_elapsed++;
        if (loss) begin nxt = P_WAIT; set = 1'b1; end
        else if (!req) nxt = P_DRAIN;
        else if (m_elapsed == RST_DLY) nxt = P_RUN;
      end
      P_RUN: begin
        if (loss) begin nxt = P_WAIT; set = 1'b1; end
        else if (!req) nxt = P_DRAIN;
      end
      default: begin
        m_elapsed++;
        if (loss) begin nxt = P_IDLE; set = 1'b1; end
        else if (m_elapsed == DRAIN_DLY) nxt = P_IDLE;
      end
    endcase
`ifdef DHS_RST_SEQ_LOCK_MON_EN
    m_lost = set || (m_lost && !lock_lost_clr_i);
`else
    m_lost = set;
`endif
    if (nxt != m_phase) begin
      m_phase = nxt; m_elapsed = 0; m_lock_run = 0;
    end
  endfunction

  // Driver: one clock edge, update model, compare all outputs shortly after the edge
  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    check_val("state",     32'(state_o),     32'(m_phase));
    check_val("clk_en",    32'(clk_en_o),    32'(m_phase inside {P_CLK_ON, P_RUN, P_DRAIN}));
    check_val("rst_n",     32'(rst_n_o),     32'(m_phase == P_RUN));
    check_val("ready",     32'(ready_o),     32'(m_phase == P_RUN));
    check_val("lock_lost", 32'(lock_lost_o), 32'(m_lost));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    arst_ni = 1'b0; rst_req_ni = 1'b0; clk_en_req_i = 1'b0;
    pll_locked_i = 1'b0; lock_lost_clr_i = 1'b0;
    #2;
    // Edge 0: reset
    step();
    check_val("rst_state", 32'(state_o), 32'd0);

    // Power-up: requests and lock present from edge 1
    arst_ni = 1'b1; rst_req_ni = 1'b1; clk_en_req_i = 1'b1; pll_locked_i = 1'b1;
    step();
    check_val("pu_wait_e1", 32'(state_o), 32'd1);
    steps(3);
    check_val("pu_clk_off_e4", 32'(clk_en_o), 32'd0);
    step();
    check_val("pu_clk_on_e5", 32'(clk_en_o), 32'd1);
    steps(7);
    check_val("pu_rst_held_e12", 32'(rst_n_o), 32'd0);
    step();
    check_val("pu_rst_rel_e13", 32'(rst_n_o), 32'd1);
    check_val("pu_ready_e13", 32'(ready_o), 32'd1);

    // Shutdown from RUN with a re-request mid-drain
    rst_req_ni = 1'b0;
    step();
    check_val("sd_drain", 32'(state_o), 32'd4);
    check_val("sd_rst_low", 32'(rst_n_o), 32'd0);
    rst_req_ni = 1'b1;
    step();
    check_val("sd_drain_hold", 32'(state_o), 32'd4);
    step();
    check_val("sd_idle", 32'(state_o), 32'd0);
    check_val("sd_clk_off", 32'(clk_en_o), 32'd0);
    step();
    check_val("sd_rewait", 32'(state_o), 32'd1);

    // Lock filter: broken run of ones must restart the count
    begin
      logic [7:0] pat;
      pat = 8'b1111_0111;
      for (int i = 0; i < 8; i++) begin
        pll_locked_i = pat[i];
        step();
        if (i == 6) check_val("filt_not_yet", 32'(state_o), 32'd1);
      end
      check_val("filt_clk_on", 32'(state_o), 32'd2);
    end

    // Reset mid CLK_ON count
    steps(5);
    arst_ni = 1'b0;
    step();
    check_val("mid_rst_state", 32'(state_o), 32'd0);
    check_val("mid_rst_clk_en", 32'(clk_en_o), 32'd0);
    arst_ni = 1'b1;
    step();
    check_val("mid_rst_restart", 32'(state_o), 32'd1);

    // Lock loss in RUN, then simultaneous clear and new loss
    steps(4 + RST_DLY);
    check_val("ll_run", 32'(state_o), 32'd3);
    pll_locked_i = 1'b0;
    step();
`ifdef DHS_RST_SEQ_LOCK_MON_EN
    check_val("ll_state", 32'(state_o), 32'd1);
    check_val("ll_flag", 32'(lock_lost_o), 32'd1);
    pll_locked_i = 1'b1;
    steps(LOCK_FILT);
    pll_locked_i = 1'b0; lock_lost_clr_i = 1'b1;
    step();
    check_val("ll_set_wins", 32'(lock_lost_o), 32'd1);
    pll_locked_i = 1'b1;
    step();
    check_val("ll_cleared", 32'(lock_lost_o), 32'd0);
    lock_lost_clr_i = 1'b0;
`else
    check_val("ll_state", 32'(state_o), 32'd3);
    check_val("ll_flag", 32'(lock_lost_o), 32'd0);
    pll_locked_i = 1'b1;
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      arst_ni         = ($urandom_range(0, 99) != 0);
      rst_req_ni      = ($urandom_range(0, 39) != 0);
      clk_en_req_i    = ($urandom_range(0, 39) != 0);
      pll_locked_i    = ($urandom_range(0, 11) != 0);
      lock_lost_clr_i = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
